// File: rtl/instr_reg_sched.sv
// Write/read scheduler for the 32-entry instruction register stack.
// Round-robin arbitration of NUM_REQ producers into the stack (one registered
// write per cycle), in-order circular readout to a single consumer, reset_n
// sequencing of the stack and a one-cycle synchronous flush.
module instr_reg_sched #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned AW      = 5
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [4*NUM_REQ-1:0]    req_opcode,
   input  logic [32*NUM_REQ-1:0]   req_op_a,
   input  logic [32*NUM_REQ-1:0]   req_op_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [67:0]             rsp_instr,
   input  logic                    flush,
   output logic [AW:0]             count,
   output logic                    ir_reset_n,
   output logic                    ir_load_en,
   output logic [AW-1:0]           ir_write_pointer,
   output logic [AW-1:0]           ir_read_pointer,
   output logic signed [31:0]      ir_operand_a,
   output logic signed [31:0]      ir_operand_b,
   output logic [3:0]              ir_opcode,
   input  logic [67:0]             ir_instruction_word
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_FLUSH
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic                init_cnt;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [IW-1:0]       last;
   logic [IW-1:0]       win;
   logic                found;
   logic                run;
   logic                can_take;
   logic                grant;
   logic                pop;
   logic [AW+1:0]       used;
   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]  rot;

   // State register plus the two-cycle stack reset counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_INIT;
         init_cnt <= 1'b0;
      end else begin
         state    <= state_nx;
         init_cnt <= (state == S_INIT);
      end
   end

   // Next-state logic and state-decoded outputs
   always_comb begin
      state_nx   = state;
      run        = 1'b0;
      ir_reset_n = 1'b1;
      case (state)
         S_INIT: begin
            ir_reset_n = 1'b0;
            if (init_cnt) state_nx = S_RUN;
         end
         S_RUN: begin
            run = 1'b1;
            if (flush) state_nx = S_FLUSH;
         end
         S_FLUSH: state_nx = S_RUN;
         default: state_nx = S_INIT;
      endcase
   end

   // Round-robin pick: rotate the valid vector so the index after the last grant is bit 0
   always_comb begin
      dbl   = {req_valid, req_valid};
      rot   = NUM_REQ'(dbl >> (32'(last) + 32'd1));
      found = 1'b0;
      win   = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!found && rot[j]) begin
            found = 1'b1;
            win   = IW'((32'(last) + 32'd1 + j) % NUM_REQ);
         end
      end
   end

   // Handshakes: free space accounts for the write still in flight
   always_comb begin
      used      = {1'b0, count} + (AW+2)'(ir_load_en);
      can_take  = used < (AW+2)'(DEPTH);
      grant     = run && !flush && can_take && found;
      req_ready = '0;
      if (grant) req_ready[win] = 1'b1;
      rsp_valid = run && (count != '0);
      pop       = rsp_valid && rsp_ready && !flush;
      rsp_instr = ir_instruction_word;
   end

   assign ir_read_pointer = rd_ptr;

   // Write issue, pointers and committed-entry count; flush discards the in-flight write's count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         last             <= IW'(NUM_REQ - 1);
         ir_load_en       <= 1'b0;
         ir_write_pointer <= '0;
         ir_operand_a     <= '0;
         ir_operand_b     <= '0;
         ir_opcode        <= '0;
      end else if (run && flush) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         ir_load_en       <= 1'b0;
         ir_write_pointer <= '0;
      end else begin
         ir_load_en <= grant;
         if (grant) begin
            ir_write_pointer <= wr_ptr;
            wr_ptr           <= wr_ptr + AW'(1);
            last             <= win;
            ir_opcode        <= req_opcode[32'(win)*4 +: 4];
            ir_operand_a     <= req_op_a[32'(win)*32 +: 32];
            ir_operand_b     <= req_op_b[32'(win)*32 +: 32];
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(ir_load_en) - (AW+1)'(pop);
      end
   end

endmodule

// File: tb/tb_instr_reg_sched.sv
// Randomized bench for instr_reg_sched. A behavioural model (queue of
// committed instructions, one in-flight slot, round-robin priority) predicts
// every output each cycle; a small array stands in for the instruction stack.
module tb_instr_reg_sched;

   localparam int N     = 2;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic                 clk;
   logic                 reset_n;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [4*N-1:0]       req_opcode;
   logic [32*N-1:0]      req_op_a;
   logic [32*N-1:0]      req_op_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [67:0]          rsp_instr;
   logic                 flush;
   logic [AW:0]          count;
   logic                 ir_reset_n;
   logic                 ir_load_en;
   logic [AW-1:0]        ir_write_pointer;
   logic [AW-1:0]        ir_read_pointer;
   logic signed [31:0]   ir_operand_a;
   logic signed [31:0]   ir_operand_b;
   logic [3:0]           ir_opcode;
   logic [67:0]          ir_instruction_word;

   instr_reg_sched #(.NUM_REQ(N), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_opcode          (req_opcode),
      .req_op_a            (req_op_a),
      .req_op_b            (req_op_b),
      .rsp_valid           (rsp_valid),
      .rsp_ready           (rsp_ready),
      .rsp_instr           (rsp_instr),
      .flush               (flush),
      .count               (count),
      .ir_reset_n          (ir_reset_n),
      .ir_load_en          (ir_load_en),
      .ir_write_pointer    (ir_write_pointer),
      .ir_read_pointer     (ir_read_pointer),
      .ir_operand_a        (ir_operand_a),
      .ir_operand_b        (ir_operand_b),
      .ir_opcode           (ir_opcode),
      .ir_instruction_word (ir_instruction_word)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction register stack stand-in: synchronous write, combinational read
   logic [67:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (!ir_reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (ir_load_en) begin
         mem[ir_write_pointer] <= {ir_opcode, ir_operand_a, ir_operand_b};
      end
   end
   assign ir_instruction_word = mem[ir_read_pointer];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model
   int          m_phase;      // 0 = stack held in reset, 1 = running, 2 = flush cycle
   int          m_init;
   int          m_last;
   logic [67:0] m_q [$];
   bit          m_inflight;
   logic [67:0] m_if_data;
   int          m_if_wp;
   int          m_wcnt;
   int          m_rcnt;

   task automatic m_reset();
      m_phase    = 0;
      m_init     = 0;
      m_last     = N - 1;
      m_q.delete();
      m_inflight = 0;
      m_if_data  = '0;
      m_if_wp    = 0;
      m_wcnt     = 0;
      m_rcnt     = 0;
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) begin
         req_opcode[i*4 +: 4] = 4'($urandom);
         req_op_a[i*32 +: 32] = $urandom;
         req_op_b[i*32 +: 32] = $urandom;
      end
   endtask

   // Check outputs at the falling edge, then advance the model across the rising edge
   task automatic step();
      logic [N-1:0] exp_ready;
      logic         exp_rv;
      int           w;
      bit           f;
      #4;
      exp_ready = '0;
      f = 0;
      w = 0;
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (m_last + k) % N;
         if (!f && req_valid[idx]) begin
            f = 1;
            w = idx;
         end
      end
      if (m_phase == 1 && !flush && f && (m_q.size() + int'(m_inflight) < DEPTH)) exp_ready[w] = 1'b1;
      exp_rv = (m_phase == 1) && (m_q.size() > 0);

      check_eq("req_ready", 68'(req_ready), 68'(exp_ready));
      check_eq("rsp_valid", 68'(rsp_valid), 68'(exp_rv));
      check_eq("count", 68'(count), 68'(m_q.size()));
      check_eq("ir_reset_n", 68'(ir_reset_n), 68'(m_phase != 0));
      check_eq("ir_load_en", 68'(ir_load_en), 68'(m_inflight));
      check_eq("ir_read_pointer", 68'(ir_read_pointer), 68'(m_rcnt % DEPTH));
      if (m_inflight) begin
         check_eq("ir_data", {ir_opcode, ir_operand_a, ir_operand_b}, m_if_data);
         check_eq("ir_write_pointer", 68'(ir_write_pointer), 68'(m_if_wp));
      end
      if (exp_rv) check_eq("rsp_instr", rsp_instr, m_q[0]);

      if (!reset_n) begin
         m_reset();
      end else if (m_phase == 0) begin
         m_init++;
         if (m_init == 2) m_phase = 1;
      end else if (m_phase == 2) begin
         m_phase = 1;
      end else if (flush) begin
         m_q.delete();
         m_inflight = 0;
         m_wcnt     = 0;
         m_rcnt     = 0;
         m_phase    = 2;
      end else begin
         if (exp_rv && rsp_ready) begin
            void'(m_q.pop_front());
            m_rcnt++;
         end
         if (m_inflight) m_q.push_back(m_if_data);
         m_inflight = 0;
         if (exp_ready != '0) begin
            m_inflight = 1;
            m_if_data  = {req_opcode[w*4 +: 4], req_op_a[w*32 +: 32], req_op_b[w*32 +: 32]};
            m_if_wp    = m_wcnt % DEPTH;
            m_wcnt++;
            m_last     = w;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pv;
      int pr;
      reset_n   = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      flush     = 1'b0;
      rand_data();
      m_reset();
      @(posedge clk);
      #1;

      // Reset held for three clocks, then the stack reset sequence
      for (int i = 0; i < 3; i++) step();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // Single write/read: ADD, a = -7, b = 12
      req_valid            = 2'b01;
      req_opcode[3:0]      = 4'h1;
      req_op_a[31:0]       = -32'sd7;
      req_op_b[31:0]       = 32'sd12;
      step();
      req_valid = '0;
      step();
      step();
      rsp_ready = 1'b1;
      step();
      step();

      // Both requesters valid for four cycles, then drain
      rsp_ready = 1'b0;
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         rand_data();
         step();
      end
      req_valid = '0;
      step();
      step();
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();

      // Fill to full with the consumer stalled, then pop one while writing one
      rsp_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         req_valid = 2'($urandom_range(1, 3));
         rand_data();
         step();
      end
      rsp_ready = 1'b1;
      req_valid = 2'b10;
      step();
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 36; i++) step();

      // Random traffic with varying pressure, occasional flush and reset
      for (int blk = 0; blk < 30; blk++) begin
         pv = $urandom_range(0, 100);
         pr = $urandom_range(0, 100);
         for (int i = 0; i < 80; i++) begin
            for (int r = 0; r < N; r++) req_valid[r] = ($urandom_range(0, 99) < pv);
            rsp_ready = ($urandom_range(0, 99) < pr);
            flush     = ($urandom_range(0, 49) == 0);
            rand_data();
            if (reset_n && $urandom_range(0, 399) == 0) begin
               reset_n = 1'b0;
               m_reset();
            end else begin
               reset_n = 1'b1;
            end
            step();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
